// File: rtl/sipo_pkg.sv
// Shared definitions for the framed serial-to-parallel deserializer.
//   clog2_min1  : counter width helper, never returns less than 1
//   bit_order_e : names the two serial bit orders
package sipo_pkg;

   typedef enum logic {
      LSB_FIRST_E = 1'b0,
      MSB_FIRST_E = 1'b1
   } bit_order_e;

   // Width of a counter covering 0..n-1, at least one bit wide.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sipo_framed_if.sv
// Serial-in / word-out bundle of the framed deserializer.
//   i_clear   : synchronous abort of the partial frame
//   i_data    : serial bit, sampled when i_shift=1
//   i_ready   : consumer accepts o_data when o_valid && i_ready
//   o_data    : completed word, stable while held
//   o_valid   : o_data holds an unconsumed word
//   o_count   : bits in the current partial frame
//   o_overrun : sticky, a completed word was dropped
// master = the deserializer, slave = the serial source / word consumer.
interface sipo_framed_if
   import sipo_pkg::*;
#(
   parameter int unsigned N = 8
);
   localparam int unsigned CW = clog2_min1(N);

   logic          i_clear;
   logic          i_data;
   logic          i_shift;
   logic          i_ready;
   logic [N-1:0]  o_data;
   logic          o_valid;
   logic [CW-1:0] o_count;
   logic          o_overrun;

   modport master (
      input  i_clear, i_data, i_shift, i_ready,
      output o_data, o_valid, o_count, o_overrun
   );

   modport slave (
      output i_clear, i_data, i_shift, i_ready,
      input  o_data, o_valid, o_count, o_overrun
   );

endinterface

// File: rtl/sipo_dir_stage.sv
// N-bit shift register with selectable shift direction.
//   clk, rst_n : clock, async active-low reset (fills with R)
//   clear      : sync clear to {N{R}}, wins over shift
//   shift, din : shift din in this cycle
//   next_c     : stage contents after shifting din in (combinational),
//                used by the parent to capture a completed word
module sipo_dir_stage
   import sipo_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter bit_order_e  ORDER = LSB_FIRST_E,
   parameter bit          R     = 1'b0
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         shift,
   input  logic         din,
   output logic [N-1:0] next_c
);

   logic [N-1:0] stage_q;

   // LSB-first enters at the top and walks down; MSB-first enters at bit 0.
   always_comb begin
      next_c = stage_q;
      if (ORDER == LSB_FIRST_E) begin
         next_c = {din, stage_q[N-1:1]};
      end else begin
         next_c = {stage_q[N-2:0], din};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= {N{R}};
      end else if (clear) begin
         stage_q <= {N{R}};
      end else if (shift) begin
         stage_q <= next_c;
      end
   end

endmodule

// File: rtl/sipo_framed.sv
// Framed serial-to-parallel deserializer with a double-buffered output word.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (master)   : serial input, clear, valid/ready word output,
//                    partial-frame count and sticky overrun
// The shift stage never stalls; a word completing while the output buffer
// is held without ready is dropped and flagged in o_overrun.
module sipo_framed
   import sipo_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter int unsigned MSB_FIRST = 0,
   parameter bit          R         = 1'b0
)(
   input  logic          i_clk,
   input  logic          i_rst_n,
   sipo_framed_if.master bus
);

   localparam int unsigned CW    = clog2_min1(N);
   localparam bit_order_e  ORDER = (MSB_FIRST != 0) ? MSB_FIRST_E : LSB_FIRST_E;

   generate
      if (N < 2) begin : g_bad_n
         $error("sipo_framed: N must be at least 2");
      end
   endgenerate

   logic [N-1:0]  word_c;
   logic          complete_c;
   logic          drain_c;
   logic [CW-1:0] count_q;
   logic [N-1:0]  data_q;
   logic          valid_q;
   logic          overrun_q;

   sipo_dir_stage #(
      .N     (N),
      .ORDER (ORDER),
      .R     (R)
   ) u_stage (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .clear  (bus.i_clear),
      .shift  (bus.i_shift),
      .din    (bus.i_data),
      .next_c (word_c)
   );

   // Clear discards the bit shifted in the same cycle, so no completion then.
   assign complete_c = bus.i_shift && !bus.i_clear && (count_q == CW'(N - 1));
   assign drain_c    = valid_q && bus.i_ready;

   // Partial-frame bit counter, wraps on completion.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else if (bus.i_clear) begin
         count_q <= '0;
      end else if (complete_c) begin
         count_q <= '0;
      end else if (bus.i_shift) begin
         count_q <= count_q + CW'(1);
      end
   end

   // Output buffer and handshake; untouched by clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_q  <= {N{R}};
         valid_q <= 1'b0;
      end else if (complete_c && (!valid_q || bus.i_ready)) begin
         data_q  <= word_c;
         valid_q <= 1'b1;
      end else if (drain_c) begin
         valid_q <= 1'b0;
      end
   end

   // Sticky overrun: a word completed while the buffer was held.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         overrun_q <= 1'b0;
      end else if (bus.i_clear) begin
         overrun_q <= 1'b0;
      end else if (complete_c && valid_q && !bus.i_ready) begin
         overrun_q <= 1'b1;
      end
   end

   assign bus.o_data    = data_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_count   = count_q;
   assign bus.o_overrun = overrun_q;

`ifdef FORMAL
   a_data_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (valid_q && !bus.i_ready) |=> $stable(data_q));
   a_count_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (32'(count_q) < N));
   a_overrun_rise : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $rose(overrun_q) |-> $past(complete_c && valid_q && !bus.i_ready));
`endif

endmodule

// File: tb/tb_sipo_framed.sv
// Directed self-checking bench for sipo_framed (N=8).
// dut0 is LSB-first, dut1 is MSB-first; both see the same serial stream.
module tb_sipo_framed;

   logic clk;
   logic rst_n;
   logic clear;
   logic sdata;
   logic shift;
   logic ready;

   int checks;
   int failures;

   sipo_framed_if #(.N(8)) bus0 ();
   sipo_framed_if #(.N(8)) bus1 ();

   assign bus0.i_clear = clear;
   assign bus0.i_data  = sdata;
   assign bus0.i_shift = shift;
   assign bus0.i_ready = ready;
   assign bus1.i_clear = clear;
   assign bus1.i_data  = sdata;
   assign bus1.i_shift = shift;
   assign bus1.i_ready = ready;

   sipo_framed #(.N(8), .MSB_FIRST(0), .R(1'b0)) dut0 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus0)
   );

   sipo_framed #(.N(8), .MSB_FIRST(1), .R(1'b0)) dut1 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One serial bit; returns 1 time unit after the sampling edge.
   task automatic send_bit(input logic b);
      sdata = b;
      shift = 1'b1;
      @(posedge clk);
      #1;
      shift = 1'b0;
      sdata = 1'b0;
   endtask

   // Word sent LSB first (dut0 reconstructs it exactly).
   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) send_bit(w[i]);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (bus0.o_valid !== 1'b0 || bus0.o_count !== 3'd0 || bus0.o_overrun !== 1'b0
          || bus0.o_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_state valid=%b count=%0d overrun=%b data=%h expected 0/0/0/00",
                  bus0.o_valid, bus0.o_count, bus0.o_overrun, bus0.o_data);
      end
      idle_cycle();
      rst_n = 1'b1;
      idle_cycle();
   endtask

   task automatic test_lsb_msb();
      logic [7:0] bits;
      bits  = 8'b0100_1101; // stream 1,0,1,1,0,0,1,0 in bits[0..7]
      ready = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(bits[i]);
      checks++;
      if (bus0.o_count !== 3'd3) begin
         failures++;
         $display("FAIL partial_count got %0d expected 3", bus0.o_count);
      end
      for (int i = 3; i < 8; i++) send_bit(bits[i]);
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_data !== 8'h4D || bus0.o_count !== 3'd0) begin
         failures++;
         $display("FAIL lsb_word valid=%b data=%h count=%0d expected 1/4d/0",
                  bus0.o_valid, bus0.o_data, bus0.o_count);
      end
      checks++;
      if (bus1.o_valid !== 1'b1 || bus1.o_data !== 8'hB2) begin
         failures++;
         $display("FAIL msb_word valid=%b data=%h expected 1/b2", bus1.o_valid, bus1.o_data);
      end
      idle_cycle();
      checks++;
      if (bus0.o_valid !== 1'b0 || bus1.o_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_drop got %b/%b expected 0/0", bus0.o_valid, bus1.o_valid);
      end
   endtask

   task automatic test_overrun();
      ready = 1'b0;
      send_word(8'hA5);
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_data !== 8'hA5 || bus0.o_overrun !== 1'b0) begin
         failures++;
         $display("FAIL hold_first valid=%b data=%h overrun=%b expected 1/a5/0",
                  bus0.o_valid, bus0.o_data, bus0.o_overrun);
      end
      send_word(8'h3C);
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_data !== 8'hA5 || bus0.o_overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set valid=%b data=%h overrun=%b expected 1/a5/1",
                  bus0.o_valid, bus0.o_data, bus0.o_overrun);
      end
      ready = 1'b1;
      idle_cycle();
      checks++;
      if (bus0.o_valid !== 1'b0 || bus0.o_overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_accept valid=%b overrun=%b expected 0/1",
                  bus0.o_valid, bus0.o_overrun);
      end
      clear = 1'b1;
      idle_cycle();
      clear = 1'b0;
      checks++;
      if (bus0.o_overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear got %b expected 0", bus0.o_overrun);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      ready = 1'b0;
      send_word(8'h11);
      w = 8'h22;
      for (int i = 0; i < 7; i++) send_bit(w[i]);
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_data !== 8'h11) begin
         failures++;
         $display("FAIL b2b_hold valid=%b data=%h expected 1/11", bus0.o_valid, bus0.o_data);
      end
      ready = 1'b1;
      send_bit(w[7]);
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_data !== 8'h22 || bus0.o_overrun !== 1'b0) begin
         failures++;
         $display("FAIL b2b_replace valid=%b data=%h overrun=%b expected 1/22/0",
                  bus0.o_valid, bus0.o_data, bus0.o_overrun);
      end
      idle_cycle();
      checks++;
      if (bus0.o_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain valid=%b expected 0", bus0.o_valid);
      end
   endtask

   task automatic test_clear_shift();
      ready = 1'b1;
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      checks++;
      if (bus0.o_count !== 3'd5) begin
         failures++;
         $display("FAIL clr_partial count=%0d expected 5", bus0.o_count);
      end
      clear = 1'b1;
      send_bit(1'b1);
      clear = 1'b0;
      checks++;
      if (bus0.o_count !== 3'd0 || bus0.o_valid !== 1'b0) begin
         failures++;
         $display("FAIL clr_with_shift count=%0d valid=%b expected 0/0",
                  bus0.o_count, bus0.o_valid);
      end
      send_word(8'h96);
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_data !== 8'h96 || bus0.o_count !== 3'd0) begin
         failures++;
         $display("FAIL clr_next_word valid=%b data=%h count=%0d expected 1/96/0",
                  bus0.o_valid, bus0.o_data, bus0.o_count);
      end
      idle_cycle();
   endtask

   task automatic test_async_reset();
      int         nvalid;
      logic [7:0] w;
      ready = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      checks++;
      if (bus0.o_count !== 3'd3) begin
         failures++;
         $display("FAIL arst_pre_count count=%0d expected 3", bus0.o_count);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus0.o_count !== 3'd0 || bus0.o_valid !== 1'b0 || bus0.o_overrun !== 1'b0) begin
         failures++;
         $display("FAIL arst_mid_frame count=%0d valid=%b overrun=%b expected 0/0/0",
                  bus0.o_count, bus0.o_valid, bus0.o_overrun);
      end
      #1 rst_n = 1'b1;
      idle_cycle();
      ready = 1'b0;
      send_word(8'h5A);
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_data !== 8'h5A) begin
         failures++;
         $display("FAIL arst_hold_pre valid=%b data=%h expected 1/5a", bus0.o_valid, bus0.o_data);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus0.o_valid !== 1'b0 || bus0.o_data !== 8'h00 || bus0.o_count !== 3'd0
          || bus1.o_valid !== 1'b0) begin
         failures++;
         $display("FAIL arst_mid_hold valid=%b data=%h count=%0d expected 0/00/0",
                  bus0.o_valid, bus0.o_data, bus0.o_count);
      end
      #1 rst_n = 1'b1;
      ready  = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 2; i++) begin
         idle_cycle();
         if (bus0.o_valid === 1'b1) nvalid++;
      end
      w = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         send_bit(w[i]);
         if (bus0.o_valid === 1'b1) nvalid++;
      end
      checks++;
      if (bus0.o_data !== 8'hC3) begin
         failures++;
         $display("FAIL arst_after_word data=%h expected c3", bus0.o_data);
      end
      for (int i = 0; i < 3; i++) begin
         idle_cycle();
         if (bus0.o_valid === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid != 1) begin
         failures++;
         $display("FAIL arst_single_valid valid_cycles=%0d expected 1", nvalid);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      clear    = 1'b0;
      sdata    = 1'b0;
      shift    = 1'b0;
      ready    = 1'b0;
      test_reset();
      test_lsb_msb();
      test_overrun();
      test_back_to_back();
      test_clear_shift();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
